// File: rtl/ifetch_queue_pkg.sv
// Shared CPU definitions used by the fetch front end: pipeline NOP,
// major opcodes, ALU op selects and the fetch-state enum.
package ifetch_queue_pkg;

   localparam logic [31:0] CPU_NOP     = 32'h0000_0020;  // add $0,$0,$0

   localparam logic [5:0]  OP_RTYPE    = 6'h00;
   localparam logic [5:0]  OP_LW       = 6'h23;
   localparam logic [5:0]  OP_SW       = 6'h2B;
   localparam logic [5:0]  OP_BEQ      = 6'h04;

   localparam logic [1:0]  ALUOP_ADD   = 2'b00;
   localparam logic [1:0]  ALUOP_SUB   = 2'b01;
   localparam logic [1:0]  ALUOP_FUNCT = 2'b10;

   typedef enum logic {RUN, DRAIN} fetch_state_t;

endpackage

// File: rtl/ifetch_queue_sync_fifo.sv
// In-order FIFO with synchronous flush; flush wins over push and pop.
// The caller never pops when empty or pushes when full.
module sync_fifo #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     flush,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head_data,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE = 1;
   localparam logic [AW:0]   CNT_ONE = 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr, wr_ptr;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= wr_ptr;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         if (push && !pop)      count <= count + CNT_ONE;
         else if (pop && !push) count <= count - CNT_ONE;
      end
   end

   always_ff @(posedge clock) begin
      if (push && !flush) mem[wr_ptr] <= push_data;
   end

   assign head_data = mem[rd_ptr];

endmodule

// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: sequential word fetches into a prefetch
// queue feeding IF/ID, with redirect flush and stale-response draining.
module ifetch_queue
   import ifetch_queue_pkg::*;
#(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_IR   = CPU_NOP
) (
   input  logic        clock,
   input  logic        reset_n,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        ifid_valid,
   output logic [31:0] ifid_ir,
   output logic [31:0] ifid_pc,
   input  logic        ifid_ready,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] ONE   = 1;
   localparam logic [CW:0]   LIMIT = (CW+1)'(DEPTH);

   fetch_state_t  state, state_nxt;
   logic [31:0]   fetch_pc, resp_pc, redir_pc;
   logic [CW-1:0] inflight, inflight_nxt, stale, stale_nxt, count;
   logic [CW:0]   occupancy;
   logic [63:0]   head;
   logic          accept, push, pop, valid;

   assign redir_pc  = redirect_pc & ~32'd3;
   assign occupancy = {1'b0, count} + {1'b0, inflight};
   assign valid     = (count != '0);

   assign imem_req_valid = (state == RUN) && !redirect_valid && (occupancy < LIMIT);
   assign imem_req_addr  = fetch_pc;
   assign accept = imem_req_valid && imem_req_ready;
   assign push   = imem_rsp_valid && (state == RUN) && !redirect_valid;
   assign pop    = valid && ifid_ready && !redirect_valid;

   sync_fifo #(
      .WIDTH (64),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset_n   (reset_n),
      .flush     (redirect_valid),
      .push      (push),
      .push_data ({resp_pc, imem_rsp_data}),
      .pop       (pop),
      .head_data (head),
      .count     (count)
   );

   // stale on redirect counts the survivors after this cycle's response
   always_comb begin
      state_nxt    = state;
      stale_nxt    = stale;
      inflight_nxt = inflight;
      if (accept)         inflight_nxt = inflight_nxt + ONE;
      if (imem_rsp_valid) inflight_nxt = inflight_nxt - ONE;
      if (redirect_valid) begin
         stale_nxt = inflight_nxt;
         state_nxt = (inflight_nxt != '0) ? DRAIN : RUN;
      end else if (state == DRAIN && imem_rsp_valid) begin
         stale_nxt = stale - ONE;
         if (stale == ONE) state_nxt = RUN;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state    <= RUN;
         fetch_pc <= {RESET_PC[31:2], 2'b00};
         resp_pc  <= {RESET_PC[31:2], 2'b00};
         inflight <= '0;
         stale    <= '0;
      end else begin
         state    <= state_nxt;
         stale    <= stale_nxt;
         inflight <= inflight_nxt;
         if (redirect_valid) begin
            fetch_pc <= redir_pc;
            resp_pc  <= redir_pc;
         end else begin
            if (accept) fetch_pc <= fetch_pc + 32'd4;
            if (push)   resp_pc  <= resp_pc + 32'd4;
         end
      end
   end

   assign ifid_valid = valid;
   assign ifid_ir    = valid ? head[31:0]  : NOP_IR;
   assign ifid_pc    = valid ? head[63:32] : '0;

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: fixed-latency in-order memory model,
// queue-level reference model checked every cycle, plus literal spot checks.
module tb_ifetch_queue;

   localparam int DEPTH = 4;
   localparam logic [31:0] NOP = 32'h0000_0020;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        imem_req_valid, imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = '0;
   logic        ifid_valid;
   logic [31:0] ifid_ir, ifid_pc;
   logic        ifid_ready = 1'b1;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;

   always #5 clock = ~clock;

   ifetch_queue #(
      .DEPTH    (DEPTH),
      .RESET_PC (32'h0000_0000),
      .NOP_IR   (NOP)
   ) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .ifid_valid     (ifid_valid),
      .ifid_ir        (ifid_ir),
      .ifid_pc        (ifid_pc),
      .ifid_ready     (ifid_ready),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc)
   );

   typedef struct {logic [31:0] pc; logic [31:0] ir;} entry_t;
   typedef struct {logic [31:0] addr; int due;} memreq_t;

   entry_t      mq[$];
   memreq_t     memq[$];
   logic [31:0] m_fetch = '0, m_resp = '0;
   int          m_infl = 0, m_stale = 0;
   int          checks = 0, failures = 0, cyc = 0, lat = 1, acc_cnt = 0;

   logic        exp_rv, s_acc, s_pop, s_rsp, s_redir, s_rst, d_acc;
   logic [31:0] s_data, s_rpc, d_addr;

   function automatic logic [31:0] memword(input logic [31:0] a);
      return a ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic compare();
      exp_rv = (m_stale == 0) && !redirect_valid && (mq.size() + m_infl < DEPTH);
      chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
      if (exp_rv) chk("req_addr", imem_req_addr, m_fetch);
      chk("ifid_valid", 32'(ifid_valid), 32'(mq.size() > 0));
      if (mq.size() > 0) begin
         chk("ifid_ir", ifid_ir, mq[0].ir);
         chk("ifid_pc", ifid_pc, mq[0].pc);
      end else begin
         chk("ifid_ir", ifid_ir, NOP);
         chk("ifid_pc", ifid_pc, 32'h0);
      end
   endtask

   task automatic model_update();
      int infl;
      if (!s_rst) begin
         mq.delete();
         m_fetch = '0;
         m_resp  = '0;
         m_infl  = 0;
         m_stale = 0;
         return;
      end
      infl = m_infl + (s_acc ? 1 : 0) - (s_rsp ? 1 : 0);
      if (s_redir) begin
         mq.delete();
         m_fetch = s_rpc & ~32'd3;
         m_resp  = m_fetch;
         m_stale = infl;
      end else begin
         if (s_pop) void'(mq.pop_front());
         if (s_rsp) begin
            if (m_stale > 0) m_stale--;
            else begin
               chk("no_overflow", 32'(mq.size() < DEPTH), 32'd1);
               mq.push_back('{m_resp, s_data});
               m_resp += 32'd4;
            end
         end
         if (s_acc) m_fetch += 32'd4;
      end
      m_infl = infl;
   endtask

   task automatic drive_rsp();
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      if (memq.size() > 0 && memq[0].due <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = memword(memq[0].addr);
         void'(memq.pop_front());
      end
   endtask

   task automatic step();
      @(negedge clock);
      if (reset_n) compare();
      else exp_rv = 1'b0;
      s_acc   = exp_rv && imem_req_ready;
      s_pop   = (mq.size() > 0) && ifid_ready;
      s_rsp   = imem_rsp_valid;
      s_data  = imem_rsp_data;
      s_redir = redirect_valid;
      s_rpc   = redirect_pc;
      s_rst   = reset_n;
      d_acc   = reset_n && imem_req_valid && imem_req_ready;
      d_addr  = imem_req_addr;
      @(posedge clock);
      model_update();
      if (!s_rst) memq.delete();
      else if (d_acc) begin
         memq.push_back('{d_addr, cyc + lat});
         acc_cnt++;
      end
      cyc++;
      #1;
      drive_rsp();
      #1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      ifid_ready = 1'b1;
      redirect_valid = 1'b0;
      step();
      step();
      reset_n = 1'b1;
      acc_cnt = 0;
   endtask

   assign imem_req_ready = 1'b1;

   initial begin
      logic [39:0] pat;

      // zero-wait stream from reset
      lat = 1;
      do_reset();
      chk("rst_ifid_valid", 32'(ifid_valid), 32'd0);
      chk("rst_ifid_ir", ifid_ir, 32'h0000_0020);
      chk("rst_ifid_pc", ifid_pc, 32'h0);
      chk("rst_req_valid", 32'(imem_req_valid), 32'd1);
      chk("rst_req_addr", imem_req_addr, 32'h0);
      step();
      chk("c1_req_addr", imem_req_addr, 32'h4);
      chk("c1_ifid_valid", 32'(ifid_valid), 32'd0);
      step();
      chk("c2_ifid_valid", 32'(ifid_valid), 32'd1);
      chk("c2_ifid_pc", ifid_pc, 32'h0);
      chk("c2_ifid_ir", ifid_ir, 32'h1357_9BDF);
      chk("c2_req_addr", imem_req_addr, 32'h8);
      step();
      chk("c3_ifid_pc", ifid_pc, 32'h4);
      run(6);

      // decode stall fills the queue, then drains back-to-back
      do_reset();
      ifid_ready = 1'b0;
      run(10);
      chk("stall_accepts", 32'(acc_cnt), 32'd4);
      chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
      chk("stall_head_pc", ifid_pc, 32'h0);
      ifid_ready = 1'b1;
      step();
      chk("rel_pc1", ifid_pc, 32'h4);
      chk("rel_req_valid", 32'(imem_req_valid), 32'd1);
      chk("rel_req_addr", imem_req_addr, 32'h10);
      step();
      chk("rel_pc2", ifid_pc, 32'h8);
      step();
      chk("rel_pc3", ifid_pc, 32'hC);
      step();
      chk("rel_pc4", ifid_pc, 32'h10);
      run(4);

      // redirect with three requests outstanding, latency 3
      lat = 3;
      do_reset();
      run(3);
      redirect_valid = 1'b1;
      redirect_pc = 32'h40;
      step();
      redirect_valid = 1'b0;
      chk("drain_c4_valid", 32'(ifid_valid), 32'd0);
      chk("drain_c4_req", 32'(imem_req_valid), 32'd0);
      step();
      chk("drain_c5_req", 32'(imem_req_valid), 32'd0);
      step();
      chk("drain_c6_req", 32'(imem_req_valid), 32'd1);
      chk("drain_c6_addr", imem_req_addr, 32'h40);
      run(3);
      chk("drain_c9_valid", 32'(ifid_valid), 32'd0);
      step();
      chk("drain_c10_valid", 32'(ifid_valid), 32'd1);
      chk("drain_c10_pc", ifid_pc, 32'h40);
      run(6);

      // redirect colliding with a response and a pop
      lat = 1;
      do_reset();
      run(3);
      chk("coll_pre_valid", 32'(ifid_valid), 32'd1);
      redirect_valid = 1'b1;
      redirect_pc = 32'h123;
      step();
      redirect_valid = 1'b0;
      chk("coll_c4_valid", 32'(ifid_valid), 32'd0);
      chk("coll_c4_addr", imem_req_addr, 32'h120);
      step();
      chk("coll_c5_valid", 32'(ifid_valid), 32'd0);
      step();
      chk("coll_c6_valid", 32'(ifid_valid), 32'd1);
      chk("coll_c6_pc", ifid_pc, 32'h120);
      run(3);

      // address wrap, then a one-cycle reset mid-stream
      do_reset();
      redirect_valid = 1'b1;
      redirect_pc = 32'hFFFF_FFF8;
      step();
      redirect_valid = 1'b0;
      chk("wrap_a0", imem_req_addr, 32'hFFFF_FFF8);
      step();
      chk("wrap_a1", imem_req_addr, 32'hFFFF_FFFC);
      step();
      chk("wrap_a2", imem_req_addr, 32'h0);
      run(3);
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      chk("mid_rst_valid", 32'(ifid_valid), 32'd0);
      chk("mid_rst_ir", ifid_ir, 32'h0000_0020);
      chk("mid_rst_pc", ifid_pc, 32'h0);
      chk("mid_rst_addr", imem_req_addr, 32'h0);
      run(5);

      // mixed stalls with redirects, including one during drain
      lat = 2;
      do_reset();
      pat = 40'hF3_7C9E_B5D6;
      for (int i = 0; i < 40; i++) begin
         ifid_ready = pat[i];
         redirect_valid = (i == 15) || (i == 17) || (i == 30);
         redirect_pc = (i == 15) ? 32'h200 : (i == 17) ? 32'h302 : 32'h500;
         step();
      end
      redirect_valid = 1'b0;
      ifid_ready = 1'b1;
      run(8);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
